layer3_pixel_buffer: RTL and testbench
======================================

Name: layer3_pixel_buffer

Overview:
- Storage and read-responder that feeds the layer-3 2x2 max-pooling stage.
- Accepts the upstream layer's pixel writes, each addressed by (row, col) and CHANNELS x 16-bit wide.
- Stores each pixel into one of four parity banks: even/even, even/odd, odd/even, odd/odd.
- Raises pixel_store_done once the full input map is written.
- Serves pooling-window reads: one (row, col) pooled address returns all four window pixels in parallel.

Parameters:
- IN_ROWS, 16, input feature-map rows (even, >=2).
- IN_COLS, 16, input feature-map columns (even, >=2).
- DATA_W, 128, pixel width (8 channels x 16 bit).
- ADDR_W, 16, row/col address width (matches WORDLENGTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_enable  in  1  write strobe from upstream layer.
- wr_row  in  ADDR_W  input-map row of write.
- wr_col  in  ADDR_W  input-map column of write.
- wr_data  in  DATA_W  pixel data.
- read_pixel_signal  in  1  read strobe from pooling stage.
- read_row_addr  in  ADDR_W  pooled row, 0..IN_ROWS/2-1.
- read_col_addr  in  ADDR_W  pooled column, 0..IN_COLS/2-1.
- layer3_calculation_done  in  1  pooling finished; releases buffer for next map.
- input_data_even_even  out  DATA_W  pixel (2r, 2c).
- input_data_even_odd  out  DATA_W  pixel (2r, 2c+1).
- input_data_odd_even  out  DATA_W  pixel (2r+1, 2c).
- input_data_odd_odd  out  DATA_W  pixel (2r+1, 2c+1).
- pixel_store_done  out  1  level; full map stored, reads valid.
- addr_error  out  1  sticky; out-of-range write/read seen.

Behaviour:
- Reset (rst=0, async):
  - State=FILL, write count=0.
  - All four data outputs=0, pixel_store_done=0, addr_error=0.
  - Bank contents are not reset.
- Bank mapping:
  - Bank select = {wr_row[0], wr_col[0]}, with 00=even_even, 01=even_odd, 10=odd_even, 11=odd_odd.
  - Bank index = (wr_row>>1)*(IN_COLS/2) + (wr_col>>1).
  - Each bank holds (IN_ROWS/2)*(IN_COLS/2) words.
- State FILL:
  - pixel_store_done=0.
  - A write with wr_enable=1 and an in-range address stores on the clock edge and increments the count.
  - When an accepted write brings the count to IN_ROWS*IN_COLS, go to READY on that same edge.
  - Duplicate addresses are counted, not deduplicated; overwriting is permitted.
- State READY:
  - pixel_store_done=1 from the cycle after the final write.
  - Writes are ignored and do not set addr_error.
  - layer3_calculation_done=1 returns to FILL and clears the count. pixel_store_done is 0 on the next cycle.
- Simultaneous events:
  - In READY, layer3_calculation_done together with wr_enable: the write is dropped and the state moves to FILL.
  - In FILL, layer3_calculation_done is ignored.
- Read path, 1-cycle latency:
  - If read_pixel_signal=1 and the address is in range, all four outputs load bank[read_row_addr*(IN_COLS/2)+read_col_addr] on the next edge.
  - If read_pixel_signal=0, outputs hold their last value.
  - Reads are honoured in any state. Content read in FILL is whatever is stored; no protection.
  - Write and read of the same word in the same cycle: the read returns the old data (read-before-write).
- Out of range:
  - Write with wr_row>=IN_ROWS or wr_col>=IN_COLS: not stored, not counted, addr_error<=1.
  - Read with read_row_addr>=IN_ROWS/2 or read_col_addr>=IN_COLS/2: outputs hold, addr_error<=1.
  - addr_error clears only on reset.
- Reset mid-fill or mid-read:
  - Immediate return to the reset values listed above.
  - Previously written pixels are not re-counted.

Test Plan:
- Reset then fill: write all 256 pixels raster order with data = {8{row*16+col}} -> pixel_store_done=0 through the 256th write edge, =1 the following cycle.
- Read window (r=3, c=5) in READY -> next cycle outputs = pixels (6,10), (6,11), (7,10), (7,11). Hold read_pixel_signal=0 -> values unchanged.
- Release and refill: in READY, pulse layer3_calculation_done together with wr_enable to (0,0) data 0xFFFF.. -> (0,0) keeps its old content, pixel_store_done=0 next cycle, and 256 new writes are needed before done=1.
- Out-of-range: write (16,0), then read (8,0) -> count unchanged, outputs unchanged, addr_error=1 until reset.
- Same-cycle write and read of pixel (0,1) in FILL, old 0x1, new 0x2 -> even_odd output=0x1; a repeat read returns 0x2.
- Async reset asserted after 100 writes -> outputs=0 immediately, state FILL; 256 further writes needed before pixel_store_done=1.

Source files
------------

// File: rtl/layer3_pixel_buffer.sv
// rtl/layer3_pixel_buffer.sv - four-bank parity pixel store feeding the 2x2 max-pool stage
module layer3_pixel_buffer #(
    parameter int IN_ROWS = 16,
    parameter int IN_COLS = 16,
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enable,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              layer3_calculation_done,
    output logic [DATA_W-1:0] input_data_even_even,
    output logic [DATA_W-1:0] input_data_even_odd,
    output logic [DATA_W-1:0] input_data_odd_even,
    output logic [DATA_W-1:0] input_data_odd_odd,
    output logic              pixel_store_done,
    output logic              addr_error
);

    localparam int BANK_DEPTH = (IN_ROWS / 2) * (IN_COLS / 2);
    localparam int IDX_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int TOTAL      = IN_ROWS * IN_COLS;
    localparam int CNT_W      = $clog2(TOTAL + 1);

    localparam logic [ADDR_W-1:0] ROWS_A      = ADDR_W'(IN_ROWS);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(IN_COLS);
    localparam logic [ADDR_W-1:0] HALF_ROWS_A = ADDR_W'(IN_ROWS / 2);
    localparam logic [ADDR_W-1:0] HALF_COLS_A = ADDR_W'(IN_COLS / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(TOTAL - 1);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] bank [4][BANK_DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_idx_full;
    logic [ADDR_W-1:0] rd_idx_full;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_in_range = (wr_row < ROWS_A) && (wr_col < COLS_A);
    assign rd_in_range = (read_row_addr < HALF_ROWS_A) && (read_col_addr < HALF_COLS_A);
    assign wr_accept   = (state == FILL) && wr_enable && wr_in_range;
    assign wr_sel      = {wr_row[0], wr_col[0]};
    assign wr_idx_full = (wr_row >> 1) * HALF_COLS_A + (wr_col >> 1);
    assign rd_idx_full = read_row_addr * HALF_COLS_A + read_col_addr;
    assign wr_idx      = wr_idx_full[IDX_W-1:0];
    assign rd_idx      = rd_idx_full[IDX_W-1:0];

    // Bank storage survives reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            bank[wr_sel][wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= FILL;
            count                <= '0;
            pixel_store_done     <= 1'b0;
            addr_error           <= 1'b0;
            input_data_even_even <= '0;
            input_data_even_odd  <= '0;
            input_data_odd_even  <= '0;
            input_data_odd_odd   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_accept) begin
                        count <= count + CNT_W'(1);
                        if (count == LAST_CNT) begin
                            state            <= READY;
                            pixel_store_done <= 1'b1;
                        end
                    end
                    if (wr_enable && !wr_in_range) begin
                        addr_error <= 1'b1;
                    end
                end
                READY: begin
                    // Any write arriving here, even with the release, is dropped.
                    if (layer3_calculation_done) begin
                        state            <= FILL;
                        count            <= '0;
                        pixel_store_done <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase

            // Bank reads see pre-edge contents, giving read-before-write.
            if (read_pixel_signal) begin
                if (rd_in_range) begin
                    input_data_even_even <= bank[0][rd_idx];
                    input_data_even_odd  <= bank[1][rd_idx];
                    input_data_odd_even  <= bank[2][rd_idx];
                    input_data_odd_odd   <= bank[3][rd_idx];
                end else begin
                    addr_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer3_pixel_buffer.sv
// tb/tb_layer3_pixel_buffer.sv - randomized self-checking bench for layer3_pixel_buffer
module tb_layer3_pixel_buffer;

    localparam int R  = 16;
    localparam int C  = 16;
    localparam int DW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_enable;
    logic [AW-1:0] wr_row;
    logic [AW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          read_pixel_signal;
    logic [AW-1:0] read_row_addr;
    logic [AW-1:0] read_col_addr;
    logic          layer3_calculation_done;
    logic [DW-1:0] input_data_even_even;
    logic [DW-1:0] input_data_even_odd;
    logic [DW-1:0] input_data_odd_even;
    logic [DW-1:0] input_data_odd_odd;
    logic          pixel_store_done;
    logic          addr_error;

    always #5 clk = ~clk;

    layer3_pixel_buffer #(.IN_ROWS(R), .IN_COLS(C), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wr_enable               (wr_enable),
        .wr_row                  (wr_row),
        .wr_col                  (wr_col),
        .wr_data                 (wr_data),
        .read_pixel_signal       (read_pixel_signal),
        .read_row_addr           (read_row_addr),
        .read_col_addr           (read_col_addr),
        .layer3_calculation_done (layer3_calculation_done),
        .input_data_even_even    (input_data_even_even),
        .input_data_even_odd     (input_data_even_odd),
        .input_data_odd_even     (input_data_odd_even),
        .input_data_odd_odd      (input_data_odd_odd),
        .pixel_store_done        (pixel_store_done),
        .addr_error              (addr_error)
    );

    int checks = 0;
    int errors = 0;

    // Reference: the input map as a plain 2-D pixel array plus fill progress.
    logic [DW-1:0] mem [R][C];
    int            m_count;
    bit            m_ready;
    bit            m_err;
    logic [DW-1:0] m_out [4];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        logic [15:0] v;
        v = 16'(r * 16 + c);
        return {8{v}};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_ready = 0;
        m_err   = 0;
        for (int i = 0; i < 4; i++) m_out[i] = '0;
    endtask

    task automatic model_edge();
        int pr, pc;
        if (read_pixel_signal) begin
            if (read_row_addr < R / 2 && read_col_addr < C / 2) begin
                pr = 2 * int'(read_row_addr);
                pc = 2 * int'(read_col_addr);
                m_out[0] = mem[pr][pc];
                m_out[1] = mem[pr][pc+1];
                m_out[2] = mem[pr+1][pc];
                m_out[3] = mem[pr+1][pc+1];
            end else begin
                m_err = 1;
            end
        end
        if (!m_ready) begin
            if (wr_enable) begin
                if (wr_row < R && wr_col < C) begin
                    mem[wr_row][wr_col] = wr_data;
                    m_count++;
                    if (m_count == R * C) m_ready = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (layer3_calculation_done) begin
            m_ready = 0;
            m_count = 0;
        end
    endtask

    task automatic check_all();
        check("ee", input_data_even_even, m_out[0]);
        check("eo", input_data_even_odd, m_out[1]);
        check("oe", input_data_odd_even, m_out[2]);
        check("oo", input_data_odd_odd, m_out[3]);
        check("done", DW'(pixel_store_done), DW'(m_ready));
        check("err", DW'(addr_error), DW'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_enable = 0;
        read_pixel_signal = 0;
        layer3_calculation_done = 0;
    endtask

    task automatic do_write(input int r, input int c, input logic [DW-1:0] d);
        wr_enable = 1;
        wr_row = AW'(r);
        wr_col = AW'(c);
        wr_data = d;
        tick();
        wr_enable = 0;
    endtask

    task automatic do_read(input int r, input int c);
        read_pixel_signal = 1;
        read_row_addr = AW'(r);
        read_col_addr = AW'(c);
        tick();
        read_pixel_signal = 0;
    endtask

    task automatic release_map();
        layer3_calculation_done = 1;
        tick();
        layer3_calculation_done = 0;
    endtask

    task automatic fill_random();
        int n = 0;
        while (!m_ready && n < 4000) begin
            do_write(int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)), rnd_data());
            n++;
        end
        check("fill_bound", DW'(pixel_store_done), DW'(1));
    endtask

    initial begin
        rst = 0;
        idle();
        wr_row = '0; wr_col = '0; wr_data = '0;
        read_row_addr = '0; read_col_addr = '0;
        #1;
        model_reset();
        check_all();
        #12 rst = 1;

        // Raster fill; done must rise only after the 256th write edge.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                do_write(r, c, pix(r, c));
                if (r == R - 1 && c == C - 2) check("done_pre", DW'(pixel_store_done), DW'(0));
            end
        check("done_post", DW'(pixel_store_done), DW'(1));

        do_read(3, 5);
        check("win_ee", input_data_even_even, pix(6, 10));
        check("win_eo", input_data_even_odd, pix(6, 11));
        check("win_oe", input_data_odd_even, pix(7, 10));
        check("win_oo", input_data_odd_odd, pix(7, 11));
        for (int i = 0; i < 3; i++) tick();
        check("hold_ee", input_data_even_even, pix(6, 10));

        // Release together with a write: the write must be dropped.
        layer3_calculation_done = 1;
        wr_enable = 1; wr_row = '0; wr_col = '0; wr_data = '1;
        tick();
        idle();
        check("rel_done", DW'(pixel_store_done), DW'(0));
        do_read(0, 0);
        check("rel_keep", input_data_even_even, pix(0, 0));

        // Same-cycle write and read of pixel (0,1).
        do_write(0, 1, DW'(1));
        read_pixel_signal = 1; read_row_addr = '0; read_col_addr = '0;
        do_write(0, 1, DW'(2));
        read_pixel_signal = 0;
        check("rbw_old", input_data_even_odd, DW'(1));
        do_read(0, 0);
        check("rbw_new", input_data_even_odd, DW'(2));

        // Out-of-range write then read while filling.
        do_write(16, 0, rnd_data());
        check("oor_err", DW'(addr_error), DW'(1));
        do_read(8, 0);
        check("oor_hold", input_data_even_odd, DW'(2));
        fill_random();

        // Async reset part way through a refill.
        release_map();
        do_read(1, 1);
        for (int i = 0; i < 100; i++)
            do_write(int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)), rnd_data());
        #2 rst = 0;
        #1;
        model_reset();
        check_all();
        check("rst_ee", input_data_even_even, DW'(0));
        #1 rst = 1;
        for (int i = 0; i < R * C - 1; i++)
            do_write(i / C, i % C, rnd_data());
        check("rst_done_pre", DW'(pixel_store_done), DW'(0));
        do_write(R - 1, C - 1, rnd_data());
        check("rst_done_post", DW'(pixel_store_done), DW'(1));

        // Mixed random traffic, including out-of-range addresses.
        for (int i = 0; i < 3000; i++) begin
            wr_enable = 1'($urandom);
            wr_row = AW'($urandom_range(0, R + 1));
            wr_col = AW'($urandom_range(0, C + 1));
            wr_data = rnd_data();
            read_pixel_signal = 1'($urandom);
            read_row_addr = AW'($urandom_range(0, R / 2));
            read_col_addr = AW'($urandom_range(0, C / 2));
            layer3_calculation_done = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
